// File: rtl/sprite_reg_file.sv
// -----------------------------------------------------------------------------
// sprite_reg_file
//
// Avalon-MM slave register bank that sits between the CPU bus and the sprite
// controller. Software writes sprite descriptors into three pending registers
// and arms a commit. At the first cycle of vertical blank the pending set is
// copied into the active descriptor outputs in one clock. The sprite
// controller only ever sees a complete set, so sprites never tear mid-frame.
// The block also counts frames and raises a level vblank interrupt.
//
// Descriptor format (pending and active):
//   {dim[31:25], id[24:20], y[19:10], x[9:0]}
// An all-zero descriptor has dim=0 and is not displayed.
//
// Address map (word addresses):
//   0..2  pending[n]           R/W
//   3     CTRL                 W: bit0 armed (value), bit1 W1C irq_pending,
//                                 bit2 irq_enable
//                              R: {frame_count[15:0], 13'b0, irq_enable,
//                                  irq_pending, armed}
//   4     ACTIVE0              R: active descriptor 0 (sprite1), writes ignored
//   5..7  reserved             R: 0, writes ignored
//
// Ports:
//   clk         system clock, same domain as the VGA timing counters
//   reset       asynchronous, active-low reset
//   chipselect  Avalon slave select; bus strobes are ignored without it
//   write       Avalon write strobe
//   read        Avalon read strobe
//   address     word address [2:0]
//   writedata   write data [31:0]
//   readdata    registered read data [31:0], read latency 1, holds otherwise
//   irq         level interrupt: irq_pending && irq_enable
//   VGA_VCOUNT  current scanline [9:0] from the VGA timing generator
//   sprite1..3  active descriptors 0..2 [31:0]
//
// Parameters:
//   VACTIVE     first VGA_VCOUNT value that is vertical blank
//   FRAME_W     frame counter width, at most 16
// -----------------------------------------------------------------------------
module sprite_reg_file #(
    parameter int VACTIVE = 480,
    parameter int FRAME_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic [9:0]  VGA_VCOUNT,
    output logic [31:0] sprite1,
    output logic [31:0] sprite2,
    output logic [31:0] sprite3
);

    localparam logic [9:0] VBLANK_LINE = 10'(VACTIVE);

    localparam logic [2:0] ADDR_PEND0   = 3'd0;
    localparam logic [2:0] ADDR_PEND1   = 3'd1;
    localparam logic [2:0] ADDR_PEND2   = 3'd2;
    localparam logic [2:0] ADDR_CTRL    = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE0 = 3'd4;

    localparam int NUM_SPRITES = 3;

    // Register state
    logic [31:0]        pending [NUM_SPRITES];
    logic               armed;
    logic               irq_pending;
    logic               irq_enable;
    logic [FRAME_W-1:0] frame_count;
    logic               vblank_q;

    // Decoded bus strobes and vblank events
    logic               wr_en;
    logic               rd_en;
    logic               ctrl_wr;
    logic [NUM_SPRITES-1:0] pend_wr;
    logic               in_vblank;
    logic               vblank_start;
    logic               commit;
    logic [15:0]        frame_count_ext;
    logic [31:0]        ctrl_word;
    logic [31:0]        read_word;

    // Bus strobes only count while the slave is selected.
    always_comb begin
        wr_en   = chipselect && write;
        rd_en   = chipselect && read;
        ctrl_wr = wr_en && (address == ADDR_CTRL);
        pend_wr = '0;
        pend_wr[0] = wr_en && (address == ADDR_PEND0);
        pend_wr[1] = wr_en && (address == ADDR_PEND1);
        pend_wr[2] = wr_en && (address == ADDR_PEND2);
    end

    // vblank_start is a one-cycle pulse on the first cycle that the scanline
    // is inside vertical blank. Because vblank_q clears on reset, a release in
    // the middle of blank is seen as a fresh start on the first cycle.
    // The commit uses the registered armed bit, so a CTRL write landing on the
    // same edge can neither create nor cancel this frame's commit.
    always_comb begin
        in_vblank    = (VGA_VCOUNT >= VBLANK_LINE);
        vblank_start = in_vblank && !vblank_q;
        commit       = vblank_start && armed;
    end

    // Edge detector history for vblank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= in_vblank;
        end
    end

    // Pending descriptors. A write on the commit edge lands here only; the
    // active outputs take the value from before the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pending[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (pend_wr[i]) begin
                    pending[i] <= writedata;
                end
            end
        end
    end

    // Active descriptors change only on a commit or on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sprite1 <= '0;
            sprite2 <= '0;
            sprite3 <= '0;
        end else if (commit) begin
            sprite1 <= pending[0];
            sprite2 <= pending[1];
            sprite3 <= pending[2];
        end
    end

    // Arm flag. An explicit CTRL write takes priority over the self-clear
    // from a commit, so arming on the vblank edge schedules the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else if (ctrl_wr) begin
            armed <= writedata[0];
        end else if (commit) begin
            armed <= 1'b0;
        end
    end

    // Interrupt state. Setting on vblank_start wins over a coincident W1C so
    // a frame event is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pending <= 1'b0;
            irq_enable  <= 1'b0;
        end else begin
            if (vblank_start) begin
                irq_pending <= 1'b1;
            end else if (ctrl_wr && writedata[1]) begin
                irq_pending <= 1'b0;
            end
            if (ctrl_wr) begin
                irq_enable <= writedata[2];
            end
        end
    end

    // Frame counter, wraps naturally at 2**FRAME_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
        end else if (vblank_start) begin
            frame_count <= frame_count + FRAME_W'(1);
        end
    end

    // Read multiplexer. Reads have no side effects.
    always_comb begin
        frame_count_ext = 16'(frame_count);
        ctrl_word       = {frame_count_ext, 13'b0, irq_enable, irq_pending, armed};
        read_word       = '0;
        case (address)
            ADDR_PEND0:   read_word = pending[0];
            ADDR_PEND1:   read_word = pending[1];
            ADDR_PEND2:   read_word = pending[2];
            ADDR_CTRL:    read_word = ctrl_word;
            ADDR_ACTIVE0: read_word = sprite1;
            default:      read_word = '0;
        endcase
    end

    // Registered read data; holds its value between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= read_word;
        end
    end

    assign irq = irq_pending && irq_enable;

endmodule

// File: tb/tb_sprite_reg_file.sv
// -----------------------------------------------------------------------------
// tb_sprite_reg_file
//
// Self-checking bench for sprite_reg_file. A small behavioural model of the
// register bank tracks the expected state; read expectations are pushed to a
// queue when a read is driven and popped when readdata becomes valid one
// cycle later. The frame counter is built narrow here so that its wrap can be
// reached in a few thousand cycles.
// -----------------------------------------------------------------------------
module tb_sprite_reg_file;

    localparam int          TB_FRAME_W = 10;
    localparam logic [15:0] FRAME_MASK = 16'((1 << TB_FRAME_W) - 1);

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [9:0]  VGA_VCOUNT;
    logic [31:0] sprite1;
    logic [31:0] sprite2;
    logic [31:0] sprite3;

    sprite_reg_file #(
        .VACTIVE (480),
        .FRAME_W (TB_FRAME_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .VGA_VCOUNT (VGA_VCOUNT),
        .sprite1    (sprite1),
        .sprite2    (sprite2),
        .sprite3    (sprite3)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    logic [31:0] mPending [3];
    logic [31:0] mSprite  [3];
    logic        mArmed;
    logic        mIrqPend;
    logic        mIrqEn;
    logic        mVq;
    logic [15:0] mFrame;
    logic [31:0] lastRd;
    logic [31:0] expQ [$];

    // Compares one observed value against its expectation.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got === want) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ctrlWord();
        return {mFrame, 13'b0, mIrqEn, mIrqPend, mArmed};
    endfunction

    // Drives one bus cycle plus a scanline value, advances the model across
    // the clock edge and checks readdata (new value after a read, held value
    // otherwise).
    task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                                 input logic [2:0] addr, input logic [31:0] wdata,
                                 input logic [9:0] vcount);
        logic        inVb;
        logic        vbStart;
        logic        commitNow;
        logic        wrEn;
        logic        rdEn;
        logic [31:0] rdWord;
        logic [31:0] expRd;

        inVb      = (vcount >= 10'd480);
        vbStart   = inVb && !mVq;
        commitNow = vbStart && mArmed;
        wrEn      = cs && wr;
        rdEn      = cs && rd;

        case (addr)
            3'd0, 3'd1, 3'd2: rdWord = mPending[addr[1:0]];
            3'd3:             rdWord = ctrlWord();
            3'd4:             rdWord = mSprite[0];
            default:          rdWord = 32'h0;
        endcase
        if (rdEn) expQ.push_back(rdWord);

        chipselect = cs;
        write      = wr;
        read       = rd;
        address    = addr;
        writedata  = wdata;
        VGA_VCOUNT = vcount;

        @(posedge clk);
        #1;

        if (commitNow) begin
            for (int i = 0; i < 3; i++) mSprite[i] = mPending[i];
        end
        if (wrEn && addr <= 3'd2) mPending[addr[1:0]] = wdata;
        if (wrEn && addr == 3'd3) begin
            mArmed = wdata[0];
            mIrqEn = wdata[2];
        end else if (commitNow) begin
            mArmed = 1'b0;
        end
        if (vbStart) mIrqPend = 1'b1;
        else if (wrEn && addr == 3'd3 && wdata[1]) mIrqPend = 1'b0;
        if (vbStart) mFrame = (mFrame + 16'd1) & FRAME_MASK;
        mVq = inVb;

        if (rdEn) begin
            expRd  = expQ.pop_front();
            lastRd = expRd;
            checkOutput("read", readdata, expRd);
        end else begin
            checkOutput("rd_hold", readdata, lastRd);
        end
    endtask

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] data, input logic [9:0] vcount);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, data, vcount);
    endtask

    task automatic busRead(input logic [2:0] addr, input logic [9:0] vcount);
        applyStimulus(1'b1, 1'b0, 1'b1, addr, 32'h0, vcount);
    endtask

    task automatic idleCycle(input logic [9:0] vcount);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, vcount);
    endtask

    // Compares the active outputs and irq against the model.
    task automatic checkState(input string tag);
        checkOutput({tag, "_sprite1"}, sprite1, mSprite[0]);
        checkOutput({tag, "_sprite2"}, sprite2, mSprite[1]);
        checkOutput({tag, "_sprite3"}, sprite3, mSprite[2]);
        checkOutput({tag, "_irq"}, 32'(irq), 32'(mIrqPend && mIrqEn));
    endtask

    // Asserts reset between clock edges, checks that outputs clear at once,
    // then releases reset mid-cycle.
    task automatic applyReset(input logic [9:0] vcount);
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0;
        VGA_VCOUNT = vcount;
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            mPending[i] = 32'h0;
            mSprite[i]  = 32'h0;
        end
        mArmed   = 1'b0;
        mIrqPend = 1'b0;
        mIrqEn   = 1'b0;
        mVq      = 1'b0;
        mFrame   = 16'h0;
        lastRd   = 32'h0;
        expQ.delete();
        checkOutput("rst_sprite1", sprite1, 32'h0);
        checkOutput("rst_sprite2", sprite2, 32'h0);
        checkOutput("rst_sprite3", sprite3, 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_readdata", readdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0;
        VGA_VCOUNT = 10'd100;

        // Power-on reset with the beam in the active region
        applyReset(10'd100);
        idleCycle(10'd100);
        checkState("post_reset");
        busRead(3'd3, 10'd100);
        checkOutput("ctrl_reset", readdata, 32'h0);

        // Unarmed vblank: no commit, but frame count and irq_pending move
        busWrite(3'd0, 32'h00E100C8, 10'd100);
        idleCycle(10'd479);
        idleCycle(10'd480);
        idleCycle(10'd480);
        checkOutput("unarmed_sprite1", sprite1, 32'h0);
        busRead(3'd3, 10'd480);
        checkOutput("unarmed_ctrl", readdata, 32'h0001_0002);

        // Armed commit of three descriptors
        idleCycle(10'd100);
        busWrite(3'd0, 32'h4030_6432, 10'd100);
        busWrite(3'd1, 32'h4420_0000, 10'd100);
        busWrite(3'd2, 32'h4632_1414, 10'd100);
        busWrite(3'd3, 32'h1, 10'd100);
        idleCycle(10'd479);
        checkOutput("precommit_sprite1", sprite1, 32'h0);
        idleCycle(10'd480);
        checkOutput("commit_sprite1", sprite1, 32'h4030_6432);
        checkOutput("commit_sprite2", sprite2, 32'h4420_0000);
        checkOutput("commit_sprite3", sprite3, 32'h4632_1414);
        busRead(3'd3, 10'd480);
        checkOutput("commit_ctrl", readdata, 32'h0002_0002);

        // Pending write on the commit edge: commit takes the old value
        idleCycle(10'd100);
        busWrite(3'd3, 32'h1, 10'd100);
        idleCycle(10'd479);
        busWrite(3'd1, 32'hFFFF_FFFF, 10'd480);
        checkOutput("collide_sprite2", sprite2, 32'h4420_0000);
        busRead(3'd1, 10'd480);
        checkOutput("collide_pend1", readdata, 32'hFFFF_FFFF);
        checkState("collide");

        // Arming on the vblank edge defers the commit to the next frame
        idleCycle(10'd100);
        busWrite(3'd0, 32'h1234_5678, 10'd100);
        idleCycle(10'd479);
        busWrite(3'd3, 32'h1, 10'd480);
        checkOutput("late_arm_sprite1", sprite1, 32'h4030_6432);
        busRead(3'd3, 10'd480);
        checkOutput("late_arm_ctrl", readdata, 32'h0004_0003);
        idleCycle(10'd100);
        idleCycle(10'd480);
        checkOutput("deferred_sprite1", sprite1, 32'h1234_5678);
        checkOutput("deferred_sprite2", sprite2, 32'hFFFF_FFFF);

        // Disarming on the vblank edge does not cancel this frame's commit
        busWrite(3'd0, 32'hCAFE_F00D, 10'd100);
        busWrite(3'd3, 32'h1, 10'd100);
        idleCycle(10'd479);
        busWrite(3'd3, 32'h0, 10'd480);
        checkOutput("disarm_sprite1", sprite1, 32'hCAFE_F00D);
        busRead(3'd3, 10'd480);
        checkOutput("disarm_ctrl", readdata, 32'h0006_0002);

        // Interrupt enable, W1C, and W1C colliding with vblank_start
        idleCycle(10'd100);
        busWrite(3'd3, 32'h2, 10'd100);
        checkOutput("irq_cleared", 32'(irq), 32'h0);
        busWrite(3'd3, 32'h4, 10'd100);
        checkOutput("irq_en_nopend", 32'(irq), 32'h0);
        idleCycle(10'd479);
        idleCycle(10'd480);
        checkOutput("irq_set", 32'(irq), 32'h1);
        idleCycle(10'd100);
        busWrite(3'd3, 32'h6, 10'd100);
        checkOutput("irq_w1c", 32'(irq), 32'h0);
        busWrite(3'd3, 32'h6, 10'd480);
        checkOutput("irq_set_wins", 32'(irq), 32'h1);
        checkState("irq");

        // Address map corners and chipselect gating
        busWrite(3'd4, 32'hDEAD_BEEF, 10'd100);
        busRead(3'd4, 10'd100);
        checkOutput("active0", readdata, 32'hCAFE_F00D);
        busWrite(3'd5, 32'h5555_AAAA, 10'd100);
        for (int a = 5; a < 8; a++) begin
            busRead(3'(a), 10'd100);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'h1111_1111, 10'd100);
        applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 32'h0, 10'd100);
        busRead(3'd0, 10'd100);
        checkOutput("nocs_write", readdata, 32'hCAFE_F00D);
        checkState("addrmap");

        // Frame counter wrap
        for (int n = 0; n < 2000 && mFrame != FRAME_MASK; n++) begin
            idleCycle(10'd100);
            idleCycle(10'd480);
        end
        busRead(3'd3, 10'd480);
        checkOutput("frame_max", 32'(readdata[31:16]), 32'(FRAME_MASK));
        idleCycle(10'd100);
        idleCycle(10'd480);
        busRead(3'd3, 10'd480);
        checkOutput("frame_wrap", 32'(readdata[31:16]), 32'h0);
        checkOutput("pre_rst_irq", 32'(irq), 32'h1);

        // Mid-frame reset while the beam is already in vertical blank
        applyReset(10'd490);
        idleCycle(10'd490);
        busRead(3'd3, 10'd490);
        checkOutput("rst_vblank_ctrl", readdata, 32'h0001_0002);
        checkState("post_midreset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
